// File: rtl/fft_twiddle_mul.sv
`default_nettype none
// ============================================================================
// fft_twiddle_mul : sum path delay-matched, difference path times W512^k,
//                   rounded half-up and saturated, 3-cycle pipeline.
// Revision 1.0
// ============================================================================
module fft_twiddle_mul #(
   parameter int IN_WIDTH  = 10,
   parameter int OUT_WIDTH = 11,
   parameter int TW_WIDTH  = 9,
   parameter int NUM       = 16,
   parameter int DATA      = 512
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic [NUM*IN_WIDTH-1:0]   di1_re,
   input  logic [NUM*IN_WIDTH-1:0]   di1_im,
   input  logic [NUM*IN_WIDTH-1:0]   di2_re,
   input  logic [NUM*IN_WIDTH-1:0]   di2_im,
   input  logic                      valid_in,
   output logic [NUM*OUT_WIDTH-1:0]  do1_re,
   output logic [NUM*OUT_WIDTH-1:0]  do1_im,
   output logic [NUM*OUT_WIDTH-1:0]  do2_re,
   output logic [NUM*OUT_WIDTH-1:0]  do2_im,
   output logic                      valid_out,
   output logic                      frame_done
);
   localparam int BEATS = DATA / (2 * NUM);
   localparam int CW    = $clog2(BEATS);
   localparam int ROM_N = DATA / 2;
   localparam int QTR   = ROM_N / 2;
   localparam int KW    = $clog2(ROM_N);
   localparam int FRAC  = TW_WIDTH - 2;
   localparam int PW    = IN_WIDTH + TW_WIDTH;
   localparam int SW    = PW + 1;
   localparam longint PI_Q30 = 64'sd3373259426;
   localparam logic signed [SW-1:0] RND     = SW'(1 << (FRAC - 1));
   localparam logic signed [SW-1:0] SAT_MAX = SW'((1 << (OUT_WIDTH - 1)) - 1);
   localparam logic signed [SW-1:0] SAT_MIN = SW'(-(1 << (OUT_WIDTH - 1)));

   // round(2^FRAC * cos(pi*m/ROM_N)) for m in [0, QTR], elaboration-time only
   function automatic int cos_q(input int m);
      longint one, x, t, acc;
      one = longint'(1) <<< 30;
      x   = (PI_Q30 * longint'(m)) / longint'(ROM_N);
      t   = one;
      acc = one;
      for (int n = 1; n < 12; n++) begin
         t   = (t * x) / one;
         t   = (t * x) / one;
         t   = -t / longint'((2 * n - 1) * (2 * n));
         acc = acc + t;
      end
      return int'(((acc <<< FRAC) + (one >>> 1)) >>> 30);
   endfunction

   function automatic logic signed [OUT_WIDTH-1:0] sat(input logic signed [SW-1:0] v);
      if (v > SAT_MAX) return SAT_MAX[OUT_WIDTH-1:0];
      if (v < SAT_MIN) return SAT_MIN[OUT_WIDTH-1:0];
      return v[OUT_WIDTH-1:0];
   endfunction

   logic signed [TW_WIDTH-1:0] rom_re [ROM_N];
   logic signed [TW_WIDTH-1:0] rom_im [ROM_N];

   // Quarter-wave symmetry keeps the series argument within [0, pi/2]
   for (genvar k = 0; k < ROM_N; k++) begin : g_rom
      localparam int M_RE = (k <= QTR) ? k : ROM_N - k;
      localparam int M_IM = (k <= QTR) ? QTR - k : k - QTR;
      localparam int C_RE = (k <= QTR) ? cos_q(M_RE) : -cos_q(M_RE);
      localparam int C_IM = -cos_q(M_IM);
      assign rom_re[k] = TW_WIDTH'(C_RE);
      assign rom_im[k] = TW_WIDTH'(C_IM);
   end

   logic [CW-1:0] cnt_d, cnt_q;
   logic s1_v_d, s1_v_q, s1_last_d, s1_last_q;
   logic s2_v_d, s2_v_q, s2_last_d, s2_last_q;
   logic s3_v_d, s3_v_q, s3_last_d, s3_last_q;
   logic signed [OUT_WIDTH-1:0] s1_d1re_d [NUM], s1_d1re_q [NUM], s1_d1im_d [NUM], s1_d1im_q [NUM];
   logic signed [OUT_WIDTH-1:0] s2_d1re_d [NUM], s2_d1re_q [NUM], s2_d1im_d [NUM], s2_d1im_q [NUM];
   logic signed [OUT_WIDTH-1:0] s3_d1re_d [NUM], s3_d1re_q [NUM], s3_d1im_d [NUM], s3_d1im_q [NUM];
   logic signed [IN_WIDTH-1:0]  s1_a_d [NUM], s1_a_q [NUM], s1_b_d [NUM], s1_b_q [NUM];
   logic signed [TW_WIDTH-1:0]  s1_c_d [NUM], s1_c_q [NUM], s1_d_d [NUM], s1_d_q [NUM];
   logic signed [PW-1:0]        s2_ac_d [NUM], s2_ac_q [NUM], s2_bd_d [NUM], s2_bd_q [NUM];
   logic signed [PW-1:0]        s2_ad_d [NUM], s2_ad_q [NUM], s2_bc_d [NUM], s2_bc_q [NUM];
   logic signed [OUT_WIDTH-1:0] s3_re_d [NUM], s3_re_q [NUM], s3_im_d [NUM], s3_im_q [NUM];

   always_comb begin
      cnt_d = cnt_q;
      if (valid_in) cnt_d = (cnt_q == CW'(BEATS - 1)) ? '0 : cnt_q + CW'(1);
      s1_v_d    = valid_in;
      s1_last_d = (cnt_q == CW'(BEATS - 1));
      s2_v_d    = s1_v_q;
      s2_last_d = s1_last_q;
      s3_v_d    = s2_v_q;
      s3_last_d = s2_last_q;
      for (int j = 0; j < NUM; j++) begin
         s1_d1re_d[j] = OUT_WIDTH'($signed(di1_re[j*IN_WIDTH +: IN_WIDTH]));
         s1_d1im_d[j] = OUT_WIDTH'($signed(di1_im[j*IN_WIDTH +: IN_WIDTH]));
         s1_a_d[j]    = $signed(di2_re[j*IN_WIDTH +: IN_WIDTH]);
         s1_b_d[j]    = $signed(di2_im[j*IN_WIDTH +: IN_WIDTH]);
         s1_c_d[j]    = rom_re[KW'(int'(cnt_q) * NUM + j)];
         s1_d_d[j]    = rom_im[KW'(int'(cnt_q) * NUM + j)];

         s2_d1re_d[j] = s1_d1re_q[j];
         s2_d1im_d[j] = s1_d1im_q[j];
         s2_ac_d[j]   = PW'(s1_a_q[j]) * PW'(s1_c_q[j]);
         s2_bd_d[j]   = PW'(s1_b_q[j]) * PW'(s1_d_q[j]);
         s2_ad_d[j]   = PW'(s1_a_q[j]) * PW'(s1_d_q[j]);
         s2_bc_d[j]   = PW'(s1_b_q[j]) * PW'(s1_c_q[j]);

         s3_d1re_d[j] = s2_d1re_q[j];
         s3_d1im_d[j] = s2_d1im_q[j];
         s3_re_d[j]   = sat((SW'(s2_ac_q[j]) - SW'(s2_bd_q[j]) + RND) >>> FRAC);
         s3_im_d[j]   = sat((SW'(s2_ad_q[j]) + SW'(s2_bc_q[j]) + RND) >>> FRAC);
      end
   end

   always_ff @(posedge clk) begin
      if (rstn) begin
         cnt_q     <= '0;
         s1_v_q    <= 1'b0;
         s1_last_q <= 1'b0;
         s2_v_q    <= 1'b0;
         s2_last_q <= 1'b0;
         s3_v_q    <= 1'b0;
         s3_last_q <= 1'b0;
         s1_d1re_q <= '{default: '0};
         s1_d1im_q <= '{default: '0};
         s2_d1re_q <= '{default: '0};
         s2_d1im_q <= '{default: '0};
         s3_d1re_q <= '{default: '0};
         s3_d1im_q <= '{default: '0};
         s1_a_q    <= '{default: '0};
         s1_b_q    <= '{default: '0};
         s1_c_q    <= '{default: '0};
         s1_d_q    <= '{default: '0};
         s2_ac_q   <= '{default: '0};
         s2_bd_q   <= '{default: '0};
         s2_ad_q   <= '{default: '0};
         s2_bc_q   <= '{default: '0};
         s3_re_q   <= '{default: '0};
         s3_im_q   <= '{default: '0};
      end else begin
         cnt_q     <= cnt_d;
         s1_v_q    <= s1_v_d;
         s1_last_q <= s1_last_d;
         s2_v_q    <= s2_v_d;
         s2_last_q <= s2_last_d;
         s3_v_q    <= s3_v_d;
         s3_last_q <= s3_last_d;
         s1_d1re_q <= s1_d1re_d;
         s1_d1im_q <= s1_d1im_d;
         s2_d1re_q <= s2_d1re_d;
         s2_d1im_q <= s2_d1im_d;
         s3_d1re_q <= s3_d1re_d;
         s3_d1im_q <= s3_d1im_d;
         s1_a_q    <= s1_a_d;
         s1_b_q    <= s1_b_d;
         s1_c_q    <= s1_c_d;
         s1_d_q    <= s1_d_d;
         s2_ac_q   <= s2_ac_d;
         s2_bd_q   <= s2_bd_d;
         s2_ad_q   <= s2_ad_d;
         s2_bc_q   <= s2_bc_d;
         s3_re_q   <= s3_re_d;
         s3_im_q   <= s3_im_d;
      end
   end

   for (genvar j = 0; j < NUM; j++) begin : g_out
      assign do1_re[j*OUT_WIDTH +: OUT_WIDTH] = s3_d1re_q[j];
      assign do1_im[j*OUT_WIDTH +: OUT_WIDTH] = s3_d1im_q[j];
      assign do2_re[j*OUT_WIDTH +: OUT_WIDTH] = s3_re_q[j];
      assign do2_im[j*OUT_WIDTH +: OUT_WIDTH] = s3_im_q[j];
   end

   assign valid_out  = s3_v_q;
   assign frame_done = s3_v_q & s3_last_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_twiddle_mul.sv
`default_nettype none
// tb_fft_twiddle_mul : scoreboard bench; expected beats come from a real-valued
// W512^k model (k=64 is e^-j*pi/4, k=128 is -j) and are popped on valid_out.
module tb_fft_twiddle_mul;
   localparam int IW = 10, OW = 11, TW = 9, NUM = 16, DATA = 512, BEATS = 16;
   localparam int IV = NUM * IW, OV = NUM * OW;
   localparam real PI = 3.141592653589793;

   logic clk = 1'b0, rstn = 1'b1, valid_in = 1'b0;
   logic [IV-1:0] di1_re = '0, di1_im = '0, di2_re = '0, di2_im = '0;
   logic [OV-1:0] do1_re, do1_im, do2_re, do2_im;
   logic valid_out, frame_done;

   fft_twiddle_mul #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .TW_WIDTH(TW), .NUM(NUM), .DATA(DATA)) dut (
      .clk(clk), .rstn(rstn),
      .di1_re(di1_re), .di1_im(di1_im), .di2_re(di2_re), .di2_im(di2_im),
      .valid_in(valid_in),
      .do1_re(do1_re), .do1_im(do1_im), .do2_re(do2_re), .do2_im(do2_im),
      .valid_out(valid_out), .frame_done(frame_done));

   always #5 clk = ~clk;

   typedef struct {
      logic [OV-1:0] d1r, d1i, d2r, d2i;
      logic          fd;
      int            cyc;
   } exp_t;

   exp_t sb[$];
   int n_chk = 0, n_pass = 0, cyc = 0, mcnt = 0;
   logic rst_seen = 1'b1;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_seen <= rstn;
   end

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic int sat_i(input int v);
      if (v > (1 << (OW - 1)) - 1) return (1 << (OW - 1)) - 1;
      if (v < -(1 << (OW - 1))) return -(1 << (OW - 1));
      return v;
   endfunction

   task automatic check_zero(input string tag);
      check({tag, "_valid_out"}, valid_out, 1'b0);
      check({tag, "_frame_done"}, frame_done, 1'b0);
      check({tag, "_do1_re"}, do1_re, '0);
      check({tag, "_do1_im"}, do1_im, '0);
      check({tag, "_do2_re"}, do2_re, '0);
      check({tag, "_do2_im"}, do2_im, '0);
   endtask

   function automatic int rnd_in();
      return int'($urandom_range(0, (1 << IW) - 1)) - (1 << (IW - 1));
   endfunction

   // Drives one valid beat; lane 0 of di2 optionally forced, other di2 lanes optionally zero
   task automatic send(input bit ovr, input int re0, input int im0, input bit zero2);
      exp_t e;
      int r1, i1, a, b, c, d, k, x, s;
      e.d1r = '0; e.d1i = '0; e.d2r = '0; e.d2i = '0;
      for (int j = 0; j < NUM; j++) begin
         r1 = rnd_in();
         i1 = rnd_in();
         a  = zero2 ? 0 : rnd_in();
         b  = zero2 ? 0 : rnd_in();
         if (ovr && j == 0) begin
            a = re0;
            b = im0;
         end
         di1_re[j*IW +: IW] = r1[IW-1:0];
         di1_im[j*IW +: IW] = i1[IW-1:0];
         di2_re[j*IW +: IW] = a[IW-1:0];
         di2_im[j*IW +: IW] = b[IW-1:0];
         k = mcnt * NUM + j;
         c = int'(128.0 * $cos(2.0 * PI * k / DATA));
         d = -int'(128.0 * $sin(2.0 * PI * k / DATA));
         e.d1r[j*OW +: OW] = r1[OW-1:0];
         e.d1i[j*OW +: OW] = i1[OW-1:0];
         x = int'($floor(real'(a * c - b * d + 64) / 128.0));
         s = sat_i(x);
         e.d2r[j*OW +: OW] = s[OW-1:0];
         x = int'($floor(real'(a * d + b * c + 64) / 128.0));
         s = sat_i(x);
         e.d2i[j*OW +: OW] = s[OW-1:0];
      end
      e.fd  = (mcnt == BEATS - 1);
      e.cyc = cyc + 3;
      valid_in = 1'b1;
      sb.push_back(e);
      mcnt = (mcnt + 1) % BEATS;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst_seen) begin
         if (valid_out) begin
            if (sb.size() == 0) begin
               check("spurious_valid_out", valid_out, 1'b0);
            end else begin
               e = sb.pop_front();
               check("latency_cycle", cyc, e.cyc);
               check("do1_re", do1_re, e.d1r);
               check("do1_im", do1_im, e.d1i);
               check("do2_re", do2_re, e.d2r);
               check("do2_im", do2_im, e.d2i);
               check("frame_done", frame_done, e.fd);
            end
         end else begin
            check("frame_done_idle", frame_done, 1'b0);
         end
      end
   end

   initial begin
      idle(3);
      check_zero("reset");
      rstn = 1'b0;
      mcnt = 0;

      // b=0: k=0 passes (100,-50) through unchanged
      send(1'b1, 100, -50, 1'b1);
      idle(4);
      send(1'b0, 0, 0, 1'b0);                 // b=1
      idle($urandom_range(0, 2));
      send(1'b1, 511, -512, 1'b0);            // b=2, k=32 -> (275,-668)
      idle($urandom_range(0, 2));
      send(1'b0, 0, 0, 1'b0);                 // b=3
      idle($urandom_range(0, 2));
      send(1'b1, 100, 50, 1'b0);              // b=4, k=64
      for (int b = 5; b < 8; b++) begin
         idle($urandom_range(0, 2));
         send(1'b0, 0, 0, 1'b0);
      end
      idle($urandom_range(0, 2));
      send(1'b1, -512, -512, 1'b0);           // b=8, k=128
      for (int b = 9; b < BEATS; b++) begin
         idle($urandom_range(0, 3));
         send(1'b0, 0, 0, 1'b0);
      end
      idle($urandom_range(0, 2));
      send(1'b0, 0, 0, 1'b0);                 // wrapped beat, k = lane index
      for (int b = 1; b < BEATS; b++) send(1'b0, 0, 0, 1'b0);
      send(1'b0, 0, 0, 1'b0);                 // next frame follows with no gap
      idle(4);

      // Mid-frame reset with valid_in held high: in-flight beats are dropped
      repeat (5) send(1'b0, 0, 0, 1'b0);
      valid_in = 1'b1;
      rstn     = 1'b1;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      check_zero("mid_reset");
      sb.delete();
      mcnt = 0;
      rstn = 1'b0;
      send(1'b0, 0, 0, 1'b0);
      send(1'b0, 0, 0, 1'b0);
      idle(1);
      send(1'b0, 0, 0, 1'b0);

      for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1);
      check("scoreboard_drained", sb.size(), 0);
      idle(3);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
`default_nettype wire
